pfi_symbol_unpacker: RTL

Read-side gearbox for the 6-bit-symbol packing path. It accepts fixed 96-bit words, each holding 16 symbols, from the upstream word stream and buffers them in a 48-symbol shift store. The consumer pulls variable-size groups of 1..16 symbols on demand. Symbol order is preserved end to end.

---
 rtl/pfi_symbol_unpacker.sv | 114 +++++++++++
 1 files changed

// File: rtl/pfi_symbol_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : pfi_symbol_unpacker
//  Purpose  : Read-side gearbox for the 6-bit-symbol packing path. Accepts
//             96-bit words (16 symbols each) into a 48-symbol shift store and
//             hands out groups of 1..16 symbols on demand, oldest first.
//  Ports    :
//    i_core_clk    core clock, rising edge
//    i_rx_rst      synchronous active-high reset
//    i_word_valid  upstream word offered
//    o_word_ready  store has room for a full word (registered fill only)
//    i_word_data   16 symbols, symbol k at [6k+5:6k], symbol 0 oldest
//    i_pop_req     consumer requests a group
//    i_pop_amount  group size minus one
//    o_pop_ready   enough symbols buffered for the current request
//    o_pop_valid   one-cycle pulse, group data valid
//    o_pop_data    group, oldest symbol at [5:0], unused symbols zero
//    o_fill        symbols currently buffered (0..48)
//  Revision : 1.0 - initial release
// ============================================================================
module pfi_symbol_unpacker #(
    parameter int SYM_W     = 6,
    parameter int WORD_SYMS = 16,
    parameter int BUF_SYMS  = 48
) (
    input  logic                         i_core_clk,
    input  logic                         i_rx_rst,
    input  logic                         i_word_valid,
    output logic                         o_word_ready,
    input  logic [SYM_W*WORD_SYMS-1:0]   i_word_data,
    input  logic                         i_pop_req,
    input  logic [$clog2(WORD_SYMS)-1:0] i_pop_amount,
    output logic                         o_pop_ready,
    output logic                         o_pop_valid,
    output logic [SYM_W*WORD_SYMS-1:0]   o_pop_data,
    output logic [$clog2(BUF_SYMS+1)-1:0] o_fill
);

    localparam int WORD_W = SYM_W * WORD_SYMS;
    localparam int BUF_W  = SYM_W * BUF_SYMS;
    localparam int FILL_W = $clog2(BUF_SYMS + 1);
    localparam int SHW    = $clog2(BUF_W) + 1;

    logic [BUF_W-1:0]  r_store;
    logic [FILL_W-1:0] r_fill;
    logic              r_pop_valid;
    logic [WORD_W-1:0] r_pop_data;

    logic [FILL_W-1:0] w_pop_n;
    logic              w_word_ready;
    logic              w_pop_ready;
    logic              w_write_fire;
    logic              w_pop_fire;
    logic [FILL_W-1:0] w_remain;
    logic [FILL_W-1:0] w_fill_next;
    logic [SHW-1:0]    w_pop_shift;
    logic [SHW-1:0]    w_wr_shift;
    logic [BUF_W-1:0]  w_after_pop;
    logic [BUF_W-1:0]  w_word_ext;
    logic [BUF_W-1:0]  w_store_next;
    logic [WORD_W-1:0] w_pop_mask;

    // All fill arithmetic stays within 0..BUF_SYMS given the ready rules,
    // so FILL_W-bit modular arithmetic is exact.
    assign w_pop_n      = FILL_W'(i_pop_amount) + FILL_W'(1);
    assign w_word_ready = !i_rx_rst && (r_fill <= FILL_W'(BUF_SYMS - WORD_SYMS));
    assign w_pop_ready  = !i_rx_rst && (r_fill >= w_pop_n);
    assign w_write_fire = i_word_valid && w_word_ready;
    assign w_pop_fire   = i_pop_req && w_pop_ready;

    // Pop is taken from the pre-write contents; the new word lands behind
    // whatever survives the pop.
    assign w_remain     = r_fill - (w_pop_fire ? w_pop_n : '0);
    assign w_fill_next  = w_remain + (w_write_fire ? FILL_W'(WORD_SYMS) : '0);
    assign w_pop_shift  = SHW'(w_pop_n) * SHW'(SYM_W);
    assign w_wr_shift   = SHW'(w_remain) * SHW'(SYM_W);
    assign w_after_pop  = w_pop_fire ? (r_store >> w_pop_shift) : r_store;
    assign w_word_ext   = {{(BUF_W - WORD_W){1'b0}}, i_word_data};
    assign w_store_next = w_after_pop | (w_write_fire ? (w_word_ext << w_wr_shift) : '0);

    // Keep only the n oldest symbols of the outgoing group.
    always_comb begin
        w_pop_mask = '0;
        for (int k = 0; k < WORD_SYMS; k++) begin
            if (k < int'(w_pop_n)) begin
                w_pop_mask[k*SYM_W +: SYM_W] = '1;
            end
        end
    end

    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_store     <= '0;
            r_fill      <= '0;
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else begin
            r_store     <= w_store_next;
            r_fill      <= w_fill_next;
            r_pop_valid <= w_pop_fire;
            if (w_pop_fire) begin
                r_pop_data <= r_store[WORD_W-1:0] & w_pop_mask;
            end
        end
    end

    assign o_word_ready = w_word_ready;
    assign o_pop_ready  = w_pop_ready;
    assign o_pop_valid  = r_pop_valid;
    assign o_pop_data   = r_pop_data;
    assign o_fill       = r_fill;

endmodule
`default_nettype wire
